// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button conditioner.
package button_pkg;

  // Debounce FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } btn_state_e;

  localparam int BTN_DEBOUNCE_DEFAULT = 4;
  localparam int BTN_REPEAT_DEFAULT   = 16;

endpackage

// File: rtl/button_conditioner_sync2.sv
// Generic two-flop synchronizer for a single asynchronous level.
module sync2 (
  input  logic CLK,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  // Two back-to-back flops; the first may go metastable, the second resolves it.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizes a raw bouncing button, debounces press
// and release, and emits one registered single-cycle pulse per accepted press.
// Optional feature macro: BUTTON_CONDITIONER_AUTO_REPEAT_EN adds a pulse train
// every REPEAT_CYCLES cycles while the button stays held.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
  parameter int REPEAT_CYCLES   = BTN_REPEAT_DEFAULT
) (
  input  logic CLK,
  input  logic Reset,
  input  logic Bi,
  output logic Bo
);

  localparam logic [7:0] DbLast = 8'(DEBOUNCE_CYCLES);

  btn_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       bo_q, bo_d;
  logic       s;
  logic       rep_fire;

  sync2 u_sync (
    .CLK   (CLK),
    .Reset (Reset),
    .d     (Bi),
    .q     (s)
  );

`ifdef BUTTON_CONDITIONER_AUTO_REPEAT_EN
  localparam logic [15:0] RepLast = 16'(REPEAT_CYCLES - 1);

  // armed_q marks a HELD that was reached through a genuine accepted press, so a
  // button held across reset never starts repeating either.
  logic [15:0] rcnt_q, rcnt_d;
  logic        armed_q, armed_d;

  assign rep_fire = armed_q && (rcnt_q == RepLast);

  // Repeat counter: clear on press acceptance, run only while HELD stays HELD,
  // freeze through release debounce.
  always_comb begin
    rcnt_d  = rcnt_q;
    armed_d = armed_q;
    if (state_q == PRESS_DB && state_d == HELD) begin
      rcnt_d  = 16'd0;
      armed_d = 1'b1;
    end else if (state_q == HELD && state_d == HELD) begin
      rcnt_d = (rcnt_q == RepLast) ? 16'd0 : rcnt_q + 16'd1;
    end
    if (state_d == IDLE) begin
      armed_d = 1'b0;
    end
  end

  // Repeat counter and arm flag registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rcnt_q  <= 16'd0;
      armed_q <= 1'b0;
    end else begin
      rcnt_q  <= rcnt_d;
      armed_q <= armed_d;
    end
  end
`else
  // REPEAT_CYCLES has no effect without the auto-repeat feature.
  logic repeat_unused;
  assign repeat_unused = (REPEAT_CYCLES > 1);
  assign rep_fire      = 1'b0;
`endif

  // Debounce FSM next-state, counter and pulse decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bo_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_DB;
          cnt_d   = 8'd1;
        end
      end
      PRESS_DB: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == DbLast) begin
          state_d = HELD;
          bo_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_DB;
          cnt_d   = 8'd1;
        end else begin
          bo_d = rep_fire;
        end
      end
      RELEASE_DB: begin
        if (s) begin
          state_d = HELD;
        end else if (cnt_q == DbLast) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = RELEASE_DB;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State, counter and output registers; reset lands in RELEASE_DB so the
  // button must be seen released before any press counts.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= RELEASE_DB;
      cnt_q   <= 8'd0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bo_q    <= bo_d;
    end
  end

  assign Bo = bo_q;

endmodule
